apu_issue_frontend: RTL and testbench
=====================================

APU_ISSUE_FRONTEND -- requirements
Module: apu_issue_frontend

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DEPTH, default 4, meaning request-queue entries (power of two, at least 2).
REQ-003 SHALL have parameter NUM_OPS, default 3, meaning operands per request.
REQ-004 SHALL have parameter OP_W, default 6, meaning opcode width.
REQ-005 SHALL have parameter FLAGS_W, default 15, meaning input flag width.
REQ-006 SHALL have these ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- apu_req  in  1  CPU request
- apu_operands_i  in  NUM_OPS x 32  operands
- apu_op  in  OP_W  opcode
- apu_flags_i  in  FLAGS_W  flags
- apu_gnt  out  1  request accepted
- apu_rvalid  out  1  result valid, one-cycle pulse
- apu_result  out  32  result
- apu_flags_o  out  5  result flags
- exec_valid  out  1  head request offered to backend
- exec_ready  in  1  backend accepts
- exec_op  out  OP_W  head opcode
- exec_operands  out  NUM_OPS x 32  head operands
- exec_flags  out  FLAGS_W  head flags
- done_valid  in  1  backend completion
- done_result  in  32  backend result
- done_flags  in  5  backend flags
- queue_count  out  $clog2(DEPTH)+1  occupancy
- protocol_err  out  1  sticky protocol error

Function
REQ-007 SHALL drive apu_gnt = apu_req AND queue not full, combinationally; a request is enqueued in the cycle apu_gnt is high.
REQ-008 SHALL NOT bypass at full: when the queue is full, apu_gnt stays low even if a dequeue occurs in the same cycle.
REQ-009 SHALL allow a simultaneous enqueue and dequeue when not full; queue_count is then unchanged.
REQ-010 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP:
- IDLE -> ISSUE when the queue is non-empty.
- ISSUE -> WAIT on exec_valid AND exec_ready, which dequeues the head.
- WAIT -> RESP on done_valid, capturing done_result and done_flags.
- RESP -> ISSUE if the queue is non-empty, else RESP -> IDLE.
REQ-011 SHALL assert exec_valid only in ISSUE; exec_op, exec_operands and exec_flags SHALL equal the head entry and be stable until accepted.
REQ-012 SHALL allow at most one request in flight; results SHALL return in request order.
REQ-013 SHALL assert apu_rvalid for exactly one cycle per completed request, in RESP, with apu_result and apu_flags_o driven from the captured registers.
REQ-014 SHALL drive apu_result and apu_flags_o to zero when apu_rvalid is low.
REQ-015 SHALL set protocol_err on done_valid outside WAIT; the flag clears only on reset, and the stray done_valid is otherwise ignored.
REQ-016 SHALL give a minimum request-to-rvalid latency of 3 cycles with exec_ready high and a one-cycle backend: enqueue at T, issue at T+1, done at T+2, rvalid at T+3.
REQ-017 SHALL wrap the queue pointers modulo DEPTH.

Reset
REQ-018 SHALL, on reset assertion, immediately return to IDLE, empty the queue, and zero apu_gnt, apu_rvalid, apu_result, apu_flags_o, exec_valid, queue_count and protocol_err.
REQ-019 SHALL discard any in-flight request when reset is asserted mid-operation; no apu_rvalid is produced for it.

Configuration
REQ-020 SHALL, with macro APU_RESULT_BYPASS_EN defined, skip RESP:
- apu_rvalid, apu_result and apu_flags_o are driven combinationally from done_valid, done_result and done_flags in WAIT.
- The FSM goes WAIT -> ISSUE or WAIT -> IDLE directly.
- Minimum latency becomes 2 cycles.
REQ-021 SHALL, without the macro, behave exactly as REQ-010 to REQ-016.

Structure
REQ-022 SHALL place the FSM state enum (apu_fe_state_t) and the queue entry struct (apu_req_entry_t: op, operands, flags) in accelerator_pkg.
REQ-023 SHALL implement the queue as sub-module apu_req_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-024 SHALL cover a single request: op=6'h05, operands {1,2,3}, exec_ready=1, one-cycle backend returning 32'hDEADBEEF -> apu_rvalid exactly 3 cycles after gnt, apu_result=32'hDEADBEEF.
REQ-025 SHALL cover a full queue: DEPTH=4 with exec_ready=0 and 5 back-to-back requests -> 4 gnts, 5th held off, queue_count=4; after exec_ready=1 the 5th is granted.
REQ-026 SHALL cover ordering: 3 requests with backend results 10, 20, 30 -> three rvalid pulses in order 10, 20, 30, never overlapping.
REQ-027 SHALL cover a stray completion: done_valid pulse in IDLE -> protocol_err=1 and sticky, no apu_rvalid.
REQ-028 SHALL cover reset mid-operation: reset asserted in WAIT -> all outputs zero within the same cycle, later done_valid ignored, queue_count=0.
REQ-029 SHALL cover bypass: with APU_RESULT_BYPASS_EN defined, a single request -> apu_rvalid in the done_valid cycle, latency 2.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared types for the APU issue front-end.
// Holds the front-end FSM state encoding and the request-queue entry layout.
// The entry field widths below are the default opcode/operand/flag sizes.
// A front-end instance must use parameters that match them.
package accelerator_pkg;

   localparam int unsigned APU_NUM_OPS  = 3;
   localparam int unsigned APU_OP_W     = 6;
   localparam int unsigned APU_FLAGS_W  = 15;
   localparam int unsigned APU_DATA_W   = 32;
   localparam int unsigned APU_RFLAGS_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } apu_fe_state_t;

   typedef struct packed {
      logic [APU_OP_W-1:0]                    op;
      logic [APU_NUM_OPS-1:0][APU_DATA_W-1:0] operands;
      logic [APU_FLAGS_W-1:0]                 flags;
   } apu_req_entry_t;

endpackage

// File: rtl/apu_req_fifo.sv
// Request queue for the APU front-end: a circular buffer of request entries.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     enqueue (ignored when full)
//   pop             dequeue the head (ignored when empty)
//   rdata           head entry
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
// DEPTH must be a power of two, so the pointers wrap modulo DEPTH by overflow.
module apu_req_fifo
   import accelerator_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  apu_req_entry_t         wdata,
   input  logic                   pop,
   output apu_req_entry_t         rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   apu_req_entry_t  mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; an entry is only read after it is written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/apu_issue_frontend.sv
// APU issue front-end: queues CPU requests, offers them one at a time to the
// backend, and returns results in request order.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   apu_req/apu_gnt                 CPU request handshake (gnt is combinational)
//   apu_op/apu_operands_i/apu_flags_i  request payload
//   apu_rvalid/apu_result/apu_flags_o  one-cycle result pulse, zero otherwise
//   exec_valid/exec_ready           head request offered to / accepted by backend
//   exec_op/exec_operands/exec_flags   head entry
//   done_valid/done_result/done_flags  backend completion
//   queue_count                     queue occupancy
//   protocol_err                    sticky: completion seen outside WAIT
// Macro APU_RESULT_BYPASS_EN: drive the result straight from the completion in
// WAIT and skip the RESP state (2-cycle minimum latency instead of 3).
module apu_issue_frontend
   import accelerator_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned NUM_OPS = APU_NUM_OPS,
   parameter int unsigned OP_W    = APU_OP_W,
   parameter int unsigned FLAGS_W = APU_FLAGS_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     apu_req,
   input  logic [NUM_OPS*32-1:0]    apu_operands_i,
   input  logic [OP_W-1:0]          apu_op,
   input  logic [FLAGS_W-1:0]       apu_flags_i,
   output logic                     apu_gnt,
   output logic                     apu_rvalid,
   output logic [31:0]              apu_result,
   output logic [4:0]               apu_flags_o,
   output logic                     exec_valid,
   input  logic                     exec_ready,
   output logic [OP_W-1:0]          exec_op,
   output logic [NUM_OPS*32-1:0]    exec_operands,
   output logic [FLAGS_W-1:0]       exec_flags,
   input  logic                     done_valid,
   input  logic [31:0]              done_result,
   input  logic [4:0]               done_flags,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic                     protocol_err
);

   apu_fe_state_t  state_q;
   apu_fe_state_t  state_d;
   apu_req_entry_t wr_entry;
   apu_req_entry_t head;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           q_avail;
   logic           err_q;

   // Grant never bypasses a full queue, and is held low during reset
   assign apu_gnt = apu_req & ~full & ~reset;
   assign push    = apu_gnt;
   assign pop     = (state_q == ISSUE) & exec_ready;
   // A request being enqueued this cycle counts, so IDLE reaches ISSUE the next cycle
   assign q_avail = ~empty | push;

   always_comb begin
      wr_entry          = '0;
      wr_entry.op       = APU_OP_W'(apu_op);
      wr_entry.operands = (APU_NUM_OPS*APU_DATA_W)'(apu_operands_i);
      wr_entry.flags    = APU_FLAGS_W'(apu_flags_i);
   end

   apu_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (queue_count)
   );

   assign exec_op       = OP_W'(head.op);
   assign exec_operands = (NUM_OPS*32)'(head.operands);
   assign exec_flags    = FLAGS_W'(head.flags);

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

`ifndef APU_RESULT_BYPASS_EN
   logic [31:0] res_q;
   logic [4:0]  rflags_q;

   // Completion capture, presented during RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q    <= '0;
         rflags_q <= '0;
      end else if ((state_q == WAIT) && done_valid) begin
         res_q    <= done_result;
         rflags_q <= done_flags;
      end
   end
`endif

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      exec_valid  = 1'b0;
      apu_rvalid  = 1'b0;
      apu_result  = '0;
      apu_flags_o = '0;
      unique case (state_q)
         IDLE: begin
            if (q_avail) state_d = ISSUE;
         end
         ISSUE: begin
            exec_valid = 1'b1;
            if (exec_ready) state_d = WAIT;
         end
         WAIT: begin
            if (done_valid) begin
`ifdef APU_RESULT_BYPASS_EN
               apu_rvalid  = 1'b1;
               apu_result  = done_result;
               apu_flags_o = done_flags;
               state_d     = q_avail ? ISSUE : IDLE;
`else
               state_d     = RESP;
`endif
            end
         end
         RESP: begin
`ifndef APU_RESULT_BYPASS_EN
            apu_rvalid  = 1'b1;
            apu_result  = res_q;
            apu_flags_o = rflags_q;
`endif
            state_d = q_avail ? ISSUE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky protocol error; a completion outside WAIT is otherwise ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              err_q <= 1'b0;
      else if (done_valid && state_q != WAIT) err_q <= 1'b1;
   end

   assign protocol_err = err_q;

endmodule

// File: tb/tb_apu_issue_frontend.sv
// Self-checking bench for apu_issue_frontend: directed steps in one initial
// block, results checked against a scoreboard by a negedge monitor.
// Honours APU_RESULT_BYPASS_EN for the expected result latency.
module tb_apu_issue_frontend;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned NUM_OPS = 3;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned FLAGS_W = 15;
`ifdef APU_RESULT_BYPASS_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 3;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   apu_req;
   logic [NUM_OPS*32-1:0]  apu_operands_i;
   logic [OP_W-1:0]        apu_op;
   logic [FLAGS_W-1:0]     apu_flags_i;
   logic                   apu_gnt;
   logic                   apu_rvalid;
   logic [31:0]            apu_result;
   logic [4:0]             apu_flags_o;
   logic                   exec_valid;
   logic                   exec_ready;
   logic [OP_W-1:0]        exec_op;
   logic [NUM_OPS*32-1:0]  exec_operands;
   logic [FLAGS_W-1:0]     exec_flags;
   logic                   done_valid;
   logic [31:0]            done_result;
   logic [4:0]             done_flags;
   logic [2:0]             queue_count;
   logic                   protocol_err;

   int          checks = 0;
   int          failures = 0;
   logic [36:0] sb [$];
   logic        prev_rvalid = 1'b0;

   apu_issue_frontend #(
      .DEPTH   (DEPTH),
      .NUM_OPS (NUM_OPS),
      .OP_W    (OP_W),
      .FLAGS_W (FLAGS_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .apu_req        (apu_req),
      .apu_operands_i (apu_operands_i),
      .apu_op         (apu_op),
      .apu_flags_i    (apu_flags_i),
      .apu_gnt        (apu_gnt),
      .apu_rvalid     (apu_rvalid),
      .apu_result     (apu_result),
      .apu_flags_o    (apu_flags_o),
      .exec_valid     (exec_valid),
      .exec_ready     (exec_ready),
      .exec_op        (exec_op),
      .exec_operands  (exec_operands),
      .exec_flags     (exec_flags),
      .done_valid     (done_valid),
      .done_result    (done_result),
      .done_flags     (done_flags),
      .queue_count    (queue_count),
      .protocol_err   (protocol_err)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling
   task automatic settle();
      #1;
   endtask

   task automatic drive_req(input logic [5:0] op, input logic [31:0] o0,
                            input logic [31:0] o1, input logic [31:0] o2,
                            input logic [14:0] fl);
      apu_req        = 1'b1;
      apu_op         = op;
      apu_operands_i = {o2, o1, o0};
      apu_flags_i    = fl;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},    32'(apu_gnt), 32'd0);
      check({tag, "_rvalid"}, 32'(apu_rvalid), 32'd0);
      check({tag, "_result"}, apu_result, 32'd0);
      check({tag, "_flags"},  32'(apu_flags_o), 32'd0);
      check({tag, "_exec_v"}, 32'(exec_valid), 32'd0);
      check({tag, "_count"},  32'(queue_count), 32'd0);
      check({tag, "_err"},    32'(protocol_err), 32'd0);
   endtask

   // Backend model: serve n queued requests in order, one-cycle completion.
   // With inflight set, the first request has already been accepted.
   task automatic drain(input int n, input bit inflight, input logic [5:0] op0,
                        input logic [31:0] res0, input logic [31:0] rstep);
      int w;
      for (int k = 0; k < n; k++) begin
         if (!(k == 0 && inflight)) begin
            exec_ready = 1'b1;
            w = 0;
            while (!exec_valid && w < 20) begin
               step();
               settle();
               w++;
            end
            check("drain_exec_valid", 32'(exec_valid), 32'd1);
            check("drain_exec_op", 32'(exec_op), 32'(op0) + 32'(k));
            step();
            exec_ready = 1'b0;
         end
         done_valid  = 1'b1;
         done_result = res0 + rstep * 32'(k);
         done_flags  = 5'(k + 1);
         sb.push_back({done_flags, done_result});
         settle();
         step();
         done_valid = 1'b0;
         settle();
      end
      exec_ready = 1'b0;
   endtask

   // Result monitor: every rvalid pulse pops the scoreboard in order
   always @(negedge clk) begin
      if (reset) begin
         prev_rvalid <= 1'b0;
      end else begin
         if (apu_rvalid) begin
            check("rvalid_back_to_back", 32'(prev_rvalid), 32'd0);
            if (sb.size() == 0) begin
               check("rvalid_unexpected", 32'(apu_rvalid), 32'd0);
            end else begin
               check("rvalid_result", apu_result, sb[0][31:0]);
               check("rvalid_flags", 32'(apu_flags_o), 32'(sb[0][36:32]));
               void'(sb.pop_front());
            end
         end else begin
            check("idle_result_zero", apu_result, 32'd0);
            check("idle_flags_zero", 32'(apu_flags_o), 32'd0);
         end
         prev_rvalid <= apu_rvalid;
      end
   end

   initial begin
      reset          = 1'b1;
      apu_req        = 1'b1;
      apu_op         = '0;
      apu_operands_i = '0;
      apu_flags_i    = '0;
      exec_ready     = 1'b0;
      done_valid     = 1'b0;
      done_result    = '0;
      done_flags     = '0;
      step();
      step();
      settle();
      check_all_zero("reset");
      step();
      reset   = 1'b0;
      apu_req = 1'b0;
      settle();

      // Single request, minimum latency
      step();
      drive_req(6'h05, 32'd1, 32'd2, 32'd3, 15'h1234);
      exec_ready = 1'b1;
      settle();
      check("single_gnt", 32'(apu_gnt), 32'd1);
      step();
      apu_req = 1'b0;
      settle();
      check("single_exec_valid", 32'(exec_valid), 32'd1);
      check("single_exec_op", 32'(exec_op), 32'h05);
      check("single_opnd0", exec_operands[31:0], 32'd1);
      check("single_opnd1", exec_operands[63:32], 32'd2);
      check("single_opnd2", exec_operands[95:64], 32'd3);
      check("single_exec_flags", 32'(exec_flags), 32'h1234);
      step();
      exec_ready  = 1'b0;
      done_valid  = 1'b1;
      done_result = 32'hDEADBEEF;
      done_flags  = 5'h0A;
      sb.push_back({5'h0A, 32'hDEADBEEF});
      settle();
      check("single_rvalid_t2", 32'(apu_rvalid), (LAT == 2) ? 32'd1 : 32'd0);
      step();
      done_valid = 1'b0;
      settle();
      check("single_rvalid_t3", 32'(apu_rvalid), (LAT == 3) ? 32'd1 : 32'd0);
      check("single_result_t3", apu_result, (LAT == 3) ? 32'hDEADBEEF : 32'd0);
      repeat (3) step();
      settle();
      check("single_sb_empty", 32'(sb.size()), 32'd0);

      // Full queue with backend stalled
      exec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         drive_req(6'(i), 32'(i), 32'(i + 1), 32'(i + 2), 15'(i));
         settle();
         check("full_gnt", 32'(apu_gnt), (i < 4) ? 32'd1 : 32'd0);
      end
      check("full_count", 32'(queue_count), 32'd4);
      step();
      exec_ready = 1'b1;
      settle();
      check("full_no_bypass_gnt", 32'(apu_gnt), 32'd0);
      check("full_head_valid", 32'(exec_valid), 32'd1);
      check("full_head_op", 32'(exec_op), 32'd0);
      step();
      exec_ready = 1'b0;
      settle();
      check("full_fifth_gnt", 32'(apu_gnt), 32'd1);
      check("full_count_after_pop", 32'(queue_count), 32'd3);
      step();
      apu_req = 1'b0;
      settle();
      check("full_count_refill", 32'(queue_count), 32'd4);
      drain(5, 1'b1, 6'd0, 32'd100, 32'd1);
      repeat (4) step();
      settle();
      check("full_sb_empty", 32'(sb.size()), 32'd0);
      check("full_count_empty", 32'(queue_count), 32'd0);

      // Ordering: three requests, results 10/20/30
      exec_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         drive_req(6'(7 + i), 32'(10 * i), 32'd0, 32'd0, 15'h0);
         settle();
         check("order_gnt", 32'(apu_gnt), 32'd1);
      end
      step();
      apu_req = 1'b0;
      settle();
      drain(3, 1'b0, 6'd7, 32'd10, 32'd10);
      repeat (4) step();
      settle();
      check("order_sb_empty", 32'(sb.size()), 32'd0);

      // Stray completion in IDLE
      check("stray_err_before", 32'(protocol_err), 32'd0);
      step();
      done_valid  = 1'b1;
      done_result = 32'h55;
      settle();
      check("stray_no_rvalid", 32'(apu_rvalid), 32'd0);
      step();
      done_valid = 1'b0;
      settle();
      check("stray_err_set", 32'(protocol_err), 32'd1);
      check("stray_no_rvalid_after", 32'(apu_rvalid), 32'd0);
      repeat (3) step();
      settle();
      check("stray_err_sticky", 32'(protocol_err), 32'd1);

      // Reset while a request is in WAIT, another queued behind it
      exec_ready = 1'b1;
      step();
      drive_req(6'h11, 32'd5, 32'd6, 32'd7, 15'h1);
      settle();
      check("rst_gnt_a", 32'(apu_gnt), 32'd1);
      step();
      drive_req(6'h12, 32'd8, 32'd9, 32'd10, 15'h2);
      settle();
      check("rst_gnt_b", 32'(apu_gnt), 32'd1);
      check("rst_issue_a", 32'(exec_valid), 32'd1);
      step();
      apu_req = 1'b0;
      settle();
      check("simul_enq_deq_count", 32'(queue_count), 32'd1);
      check("rst_in_wait", 32'(exec_valid), 32'd0);
      step();
      reset   = 1'b1;
      apu_req = 1'b1;
      settle();
      check_all_zero("rst_mid");
      step();
      reset   = 1'b0;
      apu_req = 1'b0;
      settle();
      step();
      done_valid  = 1'b1;
      done_result = 32'hBAD;
      settle();
      check("rst_late_done_rvalid", 32'(apu_rvalid), 32'd0);
      step();
      done_valid = 1'b0;
      settle();
      check("rst_count_zero", 32'(queue_count), 32'd0);
      check("rst_no_issue", 32'(exec_valid), 32'd0);
      repeat (3) step();
      settle();
      check("rst_still_idle", 32'(exec_valid), 32'd0);
      check("rst_sb_empty", 32'(sb.size()), 32'd0);
      exec_ready = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
